// File: rtl/uart_tx_pkg.sv
// Shared definitions for the serial link: FSM state encodings, line levels
// and the frame parity helper. The matching receiver imports the same package.
package uart_tx_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Zero-extended data does not change the XOR, so a fixed 8-bit port serves all widths.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period timer: registered one-cycle tick on the last clk of each bit
// period; held at the start of a period while clear is high.
module baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Tick is registered one cycle early so it lines up with cnt == CNT_LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= !clear && (cnt == CNT_PRE_LAST);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Serial transmitter: accepts a word over valid/ready and sends it LSB first
// framed as start, data, optional parity, stop.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_d, tx_ready_d, busy_d;
  logic                 baud_clear;
  logic                 bit_end;

  // The bit timer idles at zero so every frame starts on a fresh period.
  assign baud_clear = (state_q == ST_IDLE);

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx        <= IDLE_LEVEL;
      tx_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx        <= tx_d;
      tx_ready  <= tx_ready_d;
      busy      <= busy_d;
    end
  end

  // Next-state and next-output logic; tx_d is the level for the coming bit.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    parity_d   = parity_q;
    tx_d       = tx;
    tx_ready_d = tx_ready;
    busy_d     = busy;

    case (state_q)
      ST_IDLE: begin
        tx_d       = IDLE_LEVEL;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
        if (tx_valid && tx_ready) begin
          shreg_d    = tx_data;
          parity_d   = calc_parity(8'(tx_data), 1'(PARITY_ODD));
          bit_cnt_d  = '0;
          tx_d       = START_LEVEL;
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          tx_d      = shreg_q[0];
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = STOP_LEVEL;
              state_d = ST_STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            tx_d      = shreg_q[1];
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          tx_d    = STOP_LEVEL;
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          tx_d       = IDLE_LEVEL;
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        shreg_d    = '0;
        bit_cnt_d  = '0;
        tx_d       = IDLE_LEVEL;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial asynchronous transmitter. It is the sending end of the single-wire serial link whose receiving end samples the line with D flip-flops. It accepts a parallel byte through a valid/ready handshake and shifts out a framed serial stream, LSB first: start bit, data, optional parity, stop bit. It sits between any parallel producer (counter, FSM, register file) and the board TX pin.

Parameters:
CLKS_PER_BIT, 4, clk cycles per serial bit; must be >= 2.
DATA_BITS, 8, data bits per frame; range 5..8.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
tx_valid  input  1  producer has a byte on tx_data.
tx_data  input  DATA_BITS  byte to send; sampled only at handshake.
tx_ready  output  1  transmitter can accept a byte (high only in IDLE).
tx  output  1  serial line; idle level is 1.
busy  output  1  frame in progress (inverse of tx_ready).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset (async, any time, including mid-frame): state=IDLE, tx=1, tx_ready=1, busy=0, counters=0, shift register=0. A partial frame is abandoned and not resumed.
- All outputs are registered. No combinational path from inputs to outputs.
- Handshake: a transfer occurs at a posedge where tx_valid && tx_ready.
  - tx_data is latched into the shift register on that edge.
  - On that same edge: tx becomes 0 (start bit), tx_ready becomes 0, busy becomes 1.
- tx_valid and tx_data are ignored while busy. tx_valid may stay high across frames.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on handshake.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY (PARITY_EN=1) or STOP after DATA_BITS bit periods. Shift right on each bit boundary; tx = shreg[0].
  - PARITY -> STOP after one bit period. Parity bit = XOR of the latched data, XOR PARITY_ODD.
  - STOP (tx=1) -> IDLE after one bit period.
- Every bit holds tx stable for exactly CLKS_PER_BIT cycles. The bit counter and baud counter wrap to 0 at each bit boundary.
- Frame length F = (2 + DATA_BITS + PARITY_EN) * CLKS_PER_BIT cycles, measured from the handshake edge to the edge that re-enters IDLE. On that edge tx_ready becomes 1.
- Back-to-back: the earliest next handshake is the first edge after IDLE is re-entered, so frames are separated by one idle cycle (tx=1).
- Baud counter width: $clog2(CLKS_PER_BIT). Bit counter width: $clog2(DATA_BITS+1).
- tx never glitches to X. Unused state encodings recover to IDLE with tx=1.

Decomposition:
- Shared header uart_defs.vh holds:
  - state encodings (IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4);
  - idle line level constant (1'b1).
  The future uart_rx includes the same header.
- One sub-module, baud_tick. Parameter CLKS_PER_BIT; inputs clk, rst, clear; output tick, pulsed for one cycle on the last cycle of each bit period. It is reused by uart_rx.

Test Plan:
- Reset: assert rst mid-frame (during DATA bit 3) -> tx=1, tx_ready=1, busy=0 immediately, without waiting for clk; after release, a new 0x3C transmits cleanly.
- Basic frame: defaults, send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_ready returns high exactly 40 cycles after the handshake edge.
- Parity: PARITY_EN=1 with 0xA5 -> parity bit 0 (even) and 1 (odd); frame 44 cycles. 0x01 even -> parity bit 1.
- Back-to-back: tx_valid held high with 0x55 then 0xFF -> second start bit begins 41 cycles after the first handshake; exactly one idle-high cycle between frames.
- Ignore while busy: change tx_data to 0x00 and pulse tx_valid during the 0xA5 frame -> serial output is unchanged and no extra frame is sent.
- Boundary: CLKS_PER_BIT=2, DATA_BITS=5, send 5'h1F -> bits 0,1,1,1,1,1,1 each 2 cycles; frame 14 cycles.
